timer_irq_master: RTL and testbench



---
 rtl/timer_pkg.sv | 43 ++++
 rtl/hms_counter.sv | 64 ++++++
 rtl/timer_irq_master.sv | 232 +++++++++++++++++++++++
 tb/tb_timer_irq_master.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer initiator: register map, control bits, FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
// Optional build macro TIMER_CFG_VERIFY_EN adds the period read-back states VFY_L/VFY_H.
package timer_pkg;

   // Timer slave register map (16-bit registers, word addressed)
   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
   localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
   localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
   localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

   // Control register bit positions
   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   // Control words: start = ITO|CONT|START (0x0007), stop = STOP (0x0008)
   localparam logic [15:0] CTRL_START_WORD =
      16'((1 << CTRL_ITO) | (1 << CTRL_CONT) | (1 << CTRL_START));
   localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);

   typedef enum logic [2:0] {
      INIT_PL,
      INIT_PH,
`ifdef TIMER_CFG_VERIFY_EN
      VFY_L,
      VFY_H,
`endif
      IDLE,
      RUN,
      CLR_WAIT
   } state_t;

   // Saturate a load value at its legal maximum
   function automatic logic [5:0] clamp_u6(input logic [5:0] v, input logic [5:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/hms_counter.sv
// Seconds/minutes/hours time registers with carry chain, load and clamp.
// Latency: registers update on the clock edge that samples sec_pulse or set_valid.
// Backpressure: none; set_valid overrides a same-cycle sec_pulse.
// Ports: clk, reset (sync, active-high); sec_pulse advances one second; set_valid loads
// set_hh/set_mm/set_ss (clamped to 23/59/59); hours/minutes/seconds are the current time.
module hms_counter
   import timer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       sec_pulse,
   input  logic       set_valid,
   input  logic [4:0] set_hh,
   input  logic [5:0] set_mm,
   input  logic [5:0] set_ss,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds
);

   logic [4:0] hh_q, hh_d;
   logic [5:0] mm_q, mm_d;
   logic [5:0] ss_q, ss_d;

   always_comb begin
      hh_d = hh_q;
      mm_d = mm_q;
      ss_d = ss_q;
      if (set_valid) begin
         hh_d = 5'(clamp_u6({1'b0, set_hh}, 6'd23));
         mm_d = clamp_u6(set_mm, 6'd59);
         ss_d = clamp_u6(set_ss, 6'd59);
      end else if (sec_pulse) begin
         if (ss_q == 6'd59) begin
            ss_d = 6'd0;
            if (mm_q == 6'd59) begin
               mm_d = 6'd0;
               hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            end else begin
               mm_d = mm_q + 6'd1;
            end
         end else begin
            ss_d = ss_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hh_q <= 5'd0;
         mm_q <= 6'd0;
         ss_q <= 6'd0;
      end else begin
         hh_q <= hh_d;
         mm_q <= mm_d;
         ss_q <= ss_d;
      end
   end

   assign hours   = hh_q;
   assign minutes = mm_q;
   assign seconds = ss_q;

endmodule

// File: rtl/timer_irq_master.sv
// Avalon-MM initiator that programs the interval timer, services its IRQs and derives h:m:s.
// Latency: IRQ -> status-clear write 1 cycle, IRQ -> tick_pulse 2 cycles; sec_pulse shares the tick cycle.
// Backpressure: none (slave has no waitrequest); every bus write completes in a single cycle.
// Ports: clk/reset (sync, active-high); m_* Avalon-MM master to the timer; irq timer interrupt;
// enable run/stop level; set_valid + set_hh/mm/ss time load; tick_pulse/sec_pulse one-cycle
// strobes; hours/minutes/seconds current time; running timer started.
// Macro TIMER_CFG_VERIFY_EN: read back the period registers after init and flag cfg_error.
module timer_irq_master
   import timer_pkg::*;
#(
   parameter int PERIOD        = 50000,
   parameter int TICKS_PER_SEC = 1000
)(
   input  logic        clk,
   input  logic        reset,
   output logic [2:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [15:0] m_writedata,
   input  logic [15:0] m_readdata,
   input  logic        irq,
   input  logic        enable,
   input  logic        set_valid,
   input  logic [4:0]  set_hh,
   input  logic [5:0]  set_mm,
   input  logic [5:0]  set_ss,
   output logic        tick_pulse,
   output logic        sec_pulse,
   output logic [4:0]  hours,
   output logic [5:0]  minutes,
   output logic [5:0]  seconds,
   output logic        running
`ifdef TIMER_CFG_VERIFY_EN
  ,output logic        cfg_error
`endif
);

   localparam logic [31:0] PERIOD_M1 = 32'(PERIOD - 1);
   localparam logic [15:0] TPS_M1    = 16'(TICKS_PER_SEC - 1);

   state_t      state_q, state_d;
   logic        cs_q, cs_d;
   logic        wn_q, wn_d;
   logic [2:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        running_q, running_d;
   logic        tick_q, tick_d;
   // Set after a pre-start status clear so the still-high registered irq is not cleared twice
   logic        pend_q, pend_d;
   logic [15:0] tick_cnt_q, tick_cnt_d;
   logic        sec_pulse_w;

`ifdef TIMER_CFG_VERIFY_EN
   // Each verify state spans two cycles: phase 0 / phase 1
   logic        vfy_ph_q, vfy_ph_d;
   logic        err_q, err_d;
   logic        start_ok;
   assign start_ok = ~err_q;
`else
   logic        start_ok;
   logic        unused_rd;
   assign start_ok  = 1'b1;
   assign unused_rd = ^m_readdata;
`endif

   // Bus outputs are registered: the next-cycle bus action is decided here.
   always_comb begin
      state_d   = state_q;
      cs_d      = 1'b0;
      wn_d      = 1'b1;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      running_d = running_q;
      tick_d    = 1'b0;
      pend_d    = 1'b0;
`ifdef TIMER_CFG_VERIFY_EN
      vfy_ph_d  = 1'b0;
      err_d     = err_q;
`endif
      case (state_q)
         INIT_PL: begin
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = ADDR_PERIOD_L;
            wdata_d = PERIOD_M1[15:0];
            state_d = INIT_PH;
         end
         INIT_PH: begin
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = ADDR_PERIOD_H;
            wdata_d = PERIOD_M1[31:16];
`ifdef TIMER_CFG_VERIFY_EN
            state_d = VFY_L;
`else
            state_d = IDLE;
`endif
         end
`ifdef TIMER_CFG_VERIFY_EN
         // Reads are pipelined: read L, read H, then compare L and H data on the two following cycles
         VFY_L: begin
            cs_d = 1'b1;
            if (!vfy_ph_q) begin
               addr_d   = ADDR_PERIOD_L;
               vfy_ph_d = 1'b1;
            end else begin
               addr_d  = ADDR_PERIOD_H;
               state_d = VFY_H;
            end
         end
         VFY_H: begin
            if (!vfy_ph_q) begin
               if (m_readdata != PERIOD_M1[15:0]) err_d = 1'b1;
               vfy_ph_d = 1'b1;
            end else begin
               if (m_readdata != PERIOD_M1[31:16]) err_d = 1'b1;
               state_d = IDLE;
            end
         end
`endif
         IDLE: begin
            if (enable && start_ok) begin
               if (irq && !pend_q) begin
                  // Stale timeout left over from a stop: clear it before restarting
                  cs_d    = 1'b1;
                  wn_d    = 1'b0;
                  addr_d  = ADDR_STATUS;
                  wdata_d = 16'h0000;
                  pend_d  = 1'b1;
               end else begin
                  cs_d      = 1'b1;
                  wn_d      = 1'b0;
                  addr_d    = ADDR_CONTROL;
                  wdata_d   = CTRL_START_WORD;
                  running_d = 1'b1;
                  state_d   = RUN;
               end
            end
         end
         RUN: begin
            // Stop wins over a pending IRQ; the next start clears the status
            if (!enable) begin
               cs_d      = 1'b1;
               wn_d      = 1'b0;
               addr_d    = ADDR_CONTROL;
               wdata_d   = CTRL_STOP_WORD;
               running_d = 1'b0;
               state_d   = IDLE;
            end else if (irq) begin
               cs_d    = 1'b1;
               wn_d    = 1'b0;
               addr_d  = ADDR_STATUS;
               wdata_d = 16'h0000;
               state_d = CLR_WAIT;
            end
         end
         CLR_WAIT: begin
            tick_d  = 1'b1;
            state_d = RUN;
         end
         default: state_d = INIT_PL;
      endcase
   end

   // A load drops the same-cycle tick and restarts the sub-second count
   always_comb begin
      sec_pulse_w = tick_q && !set_valid && (tick_cnt_q == TPS_M1);
      tick_cnt_d  = tick_cnt_q;
      if (set_valid) begin
         tick_cnt_d = 16'd0;
      end else if (tick_q) begin
         tick_cnt_d = (tick_cnt_q == TPS_M1) ? 16'd0 : tick_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT_PL;
         cs_q       <= 1'b0;
         wn_q       <= 1'b1;
         addr_q     <= 3'd0;
         wdata_q    <= 16'h0000;
         running_q  <= 1'b0;
         tick_q     <= 1'b0;
         pend_q     <= 1'b0;
         tick_cnt_q <= 16'd0;
`ifdef TIMER_CFG_VERIFY_EN
         vfy_ph_q   <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cs_q       <= cs_d;
         wn_q       <= wn_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         running_q  <= running_d;
         tick_q     <= tick_d;
         pend_q     <= pend_d;
         tick_cnt_q <= tick_cnt_d;
`ifdef TIMER_CFG_VERIFY_EN
         vfy_ph_q   <= vfy_ph_d;
         err_q      <= err_d;
`endif
      end
   end

   assign m_chipselect = cs_q;
   assign m_write_n    = wn_q;
   assign m_address    = addr_q;
   assign m_writedata  = wdata_q;
   assign running      = running_q;
   assign tick_pulse   = tick_q;
   assign sec_pulse    = sec_pulse_w;
`ifdef TIMER_CFG_VERIFY_EN
   assign cfg_error    = err_q;
`endif

   hms_counter u_hms (
      .clk       (clk),
      .reset     (reset),
      .sec_pulse (sec_pulse_w),
      .set_valid (set_valid),
      .set_hh    (set_hh),
      .set_mm    (set_mm),
      .set_ss    (set_ss),
      .hours     (hours),
      .minutes   (minutes),
      .seconds   (seconds)
   );

endmodule

// File: tb/tb_timer_irq_master.sv
// Scoreboard bench for timer_irq_master: expected bus writes and ticks are queued with due cycles.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_timer_irq_master;

   logic        clk = 1'b0;
   logic        reset, irq, enable, set_valid;
   logic [4:0]  set_hh;
   logic [5:0]  set_mm, set_ss;
   logic [15:0] m_readdata;
   logic [2:0]  m_address;
   logic        m_chipselect, m_write_n;
   logic [15:0] m_writedata;
   logic        tick_pulse, sec_pulse, running;
   logic [4:0]  hours;
   logic [5:0]  minutes, seconds;

   always #5 clk = ~clk;

   timer_irq_master #(.PERIOD(50000), .TICKS_PER_SEC(4)) dut (
      .clk(clk), .reset(reset),
      .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
      .m_writedata(m_writedata), .m_readdata(m_readdata),
      .irq(irq), .enable(enable), .set_valid(set_valid),
      .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
      .tick_pulse(tick_pulse), .sec_pulse(sec_pulse),
      .hours(hours), .minutes(minutes), .seconds(seconds), .running(running)
   );

   typedef struct { logic [2:0] addr; logic [15:0] data; int due; } wr_t;
   typedef struct { bit sec; int due; } tk_t;

   wr_t exp_wr[$];
   tk_t exp_tk[$];
   wr_t mon_w;
   tk_t mon_t;
   int  cyc     = 0;
   int  n_total = 0;
   int  n_bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every bus access and every tick is matched against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (m_chipselect) begin
            n_total++;
            if (m_write_n) begin
               n_bad++;
               $display("FAIL bus_read: unexpected read strobe addr=%0d cyc=%0d", m_address, cyc);
            end else if (exp_wr.size() == 0) begin
               n_bad++;
               $display("FAIL bus_write: unexpected write addr=%0d data=%h cyc=%0d",
                        m_address, m_writedata, cyc);
            end else begin
               mon_w = exp_wr.pop_front();
               if (m_address !== mon_w.addr || m_writedata !== mon_w.data || cyc != mon_w.due) begin
                  n_bad++;
                  $display("FAIL bus_write: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                           m_address, m_writedata, cyc, mon_w.addr, mon_w.data, mon_w.due);
               end
            end
         end
         if (tick_pulse) begin
            n_total++;
            if (exp_tk.size() == 0) begin
               n_bad++;
               $display("FAIL tick: unexpected tick_pulse cyc=%0d", cyc);
            end else begin
               mon_t = exp_tk.pop_front();
               if (sec_pulse !== mon_t.sec || cyc != mon_t.due) begin
                  n_bad++;
                  $display("FAIL tick: got sec_pulse=%0b cyc=%0d want sec_pulse=%0b cyc=%0d",
                           sec_pulse, cyc, mon_t.sec, mon_t.due);
               end
            end
         end else if (sec_pulse) begin
            n_total++;
            n_bad++;
            $display("FAIL sec_pulse: asserted without tick_pulse cyc=%0d", cyc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic set_time(input logic [4:0] hh, input logic [5:0] mm, input logic [5:0] ss);
      set_hh = hh; set_mm = mm; set_ss = ss;
      set_valid = 1'b1;
      step(1);
      set_valid = 1'b0;
   endtask

   // Raise irq while in RUN: status clear due next cycle, tick the cycle after.
   // With do_set, set_valid is driven during the tick cycle.
   task automatic service_irq(input bit exp_sec, input bit do_set,
                              input logic [4:0] hh, input logic [5:0] mm, input logic [5:0] ss);
      irq = 1'b1;
      exp_wr.push_back('{3'd0, 16'h0000, cyc + 1});
      exp_tk.push_back('{exp_sec, cyc + 2});
      step(1);
      step(1);
      irq = 1'b0;
      if (do_set) set_time(hh, mm, ss);
      step(3);
   endtask

   initial begin
      reset = 1'b1; irq = 1'b0; enable = 1'b0; set_valid = 1'b0;
      set_hh = '0; set_mm = '0; set_ss = '0; m_readdata = 16'h0000;
      step(2);
      chk("rst_cs",      32'(m_chipselect), 32'd0);
      chk("rst_write_n", 32'(m_write_n),    32'd1);
      chk("rst_addr",    32'(m_address),    32'd0);
      chk("rst_wdata",   32'(m_writedata),  32'd0);
      chk("rst_running", 32'(running),      32'd0);
      chk("rst_time",    {15'd0, hours, minutes, seconds}, 32'd0);
      chk("rst_pulses",  {30'd0, tick_pulse, sec_pulse}, 32'd0);

      // Init writes of PERIOD-1 = 49999 = 0x0000C34F, then quiet bus
      exp_wr.push_back('{3'd2, 16'hC34F, cyc + 1});
      exp_wr.push_back('{3'd3, 16'h0000, cyc + 2});
      reset = 1'b0;
      step(8);
      chk("idle_running", 32'(running), 32'd0);

      // Start
      enable = 1'b1;
      exp_wr.push_back('{3'd1, 16'h0007, cyc + 1});
      step(1);
      chk("start_running", 32'(running), 32'd1);
      step(2);

      // Four serviced IRQs make one second at TICKS_PER_SEC=4
      for (int i = 0; i < 4; i++) service_irq(i == 3, 1'b0, 5'd0, 6'd0, 6'd0);
      chk("one_sec_s", 32'(seconds), 32'd1);
      chk("one_sec_m", 32'(minutes), 32'd0);
      chk("one_sec_h", 32'(hours),   32'd0);

      // Midnight rollover
      set_time(5'd23, 6'd59, 6'd59);
      chk("load_h", 32'(hours), 32'd23);
      chk("load_m", 32'(minutes), 32'd59);
      chk("load_s", 32'(seconds), 32'd59);
      for (int i = 0; i < 4; i++) service_irq(i == 3, 1'b0, 5'd0, 6'd0, 6'd0);
      chk("wrap_time", {15'd0, hours, minutes, seconds}, 32'd0);

      // Clamp of out-of-range load values
      set_time(5'd31, 6'd63, 6'd63);
      chk("clamp_h", 32'(hours), 32'd23);
      chk("clamp_m", 32'(minutes), 32'd59);
      chk("clamp_s", 32'(seconds), 32'd59);

      // Load coincident with the second-completing tick: tick dropped, counter cleared
      for (int i = 0; i < 3; i++) service_irq(1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
      service_irq(1'b0, 1'b1, 5'd10, 6'd20, 6'd30);
      chk("coinc_h", 32'(hours), 32'd10);
      chk("coinc_m", 32'(minutes), 32'd20);
      chk("coinc_s", 32'(seconds), 32'd30);
      for (int i = 0; i < 4; i++) service_irq(i == 3, 1'b0, 5'd0, 6'd0, 6'd0);
      chk("after_coinc_s", 32'(seconds), 32'd31);
      chk("after_coinc_m", 32'(minutes), 32'd20);

      // Stop with irq pending: only the stop write, no status clear, no tick
      enable = 1'b0;
      irq = 1'b1;
      exp_wr.push_back('{3'd1, 16'h0008, cyc + 1});
      step(1);
      chk("stop_running", 32'(running), 32'd0);
      step(3);

      // Restart with the stale irq still high: status clear precedes the start write
      enable = 1'b1;
      exp_wr.push_back('{3'd0, 16'h0000, cyc + 1});
      exp_wr.push_back('{3'd1, 16'h0007, cyc + 2});
      step(1);
      irq = 1'b0;
      step(1);
      chk("restart_running", 32'(running), 32'd1);
      step(4);

      chk("wr_queue_left",   32'(exp_wr.size()), 32'd0);
      chk("tick_queue_left", 32'(exp_tk.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
